// File: rtl/z80_bus_arbiter_pkg.sv
// rtl/z80_bus_arbiter_pkg.sv - shared encodings and constants for the DMA bus arbiter
package z80_bus_arbiter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CPU_REQ = 3'd1;
    localparam logic [2:0] ST_GRANT   = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_CPU_REL = 3'd4;

    localparam int GAP_CNT_W = 4;

    localparam logic [15:0] BUS_IDLE_ADDR = 16'h0000;
    localparam logic [7:0]  BUS_IDLE_DATA = 8'h00;

endpackage

// File: rtl/z80_bus_arbiter_rr_pick.sv
// rtl/z80_bus_arbiter_rr_pick.sv - combinational round-robin selector, first set bit at or above ptr_i with wrap
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    logic [N-1:0] rot;
    logic [W:0]   ofs;
    logic [W:0]   sum;

    always_comb begin
        // rotate so that bit 0 is the master the pointer names
        rot     = N'({req_i, req_i} >> ptr_i);
        valid_o = 1'b0;
        ofs     = '0;
        for (int i = 0; i < N; i++) begin
            if (!valid_o && rot[i]) begin
                valid_o = 1'b1;
                ofs     = (W+1)'(i);
            end
        end
        sum = {1'b0, ptr_i} + ofs;
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        idx_o = sum[W-1:0];
    end

endmodule

// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - BUSRQ/BUSAK arbiter granting the TV80 system bus to one DMA master at a time
module z80_bus_arbiter
    import z80_bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int GAP_CYCLES = 1,
    parameter int OWN_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_MASTERS-1:0]    req_n,
    output logic [N_MASTERS-1:0]    gnt_n,
    output logic                    cpu_busrq_n,
    input  logic                    cpu_busak_n,
    input  logic [16*N_MASTERS-1:0] m_addr,
    input  logic [8*N_MASTERS-1:0]  m_data,
    input  logic [N_MASTERS-1:0]    m_iorq_n,
    input  logic [N_MASTERS-1:0]    m_mreq_n,
    input  logic [N_MASTERS-1:0]    m_rd_n,
    input  logic [N_MASTERS-1:0]    m_wr_n,
    output logic [15:0]             bus_addr,
    output logic [7:0]              bus_data,
    output logic                    bus_iorq_n,
    output logic                    bus_mreq_n,
    output logic                    bus_rd_n,
    output logic                    bus_wr_n,
    output logic [OWN_W-1:0]        owner,
    output logic                    busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

    logic [2:0]           state_q,   state_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [OWN_W-1:0]     ptr_q,     ptr_d;
    logic [OWN_W-1:0]     owner_q,   owner_d;
    logic [N_MASTERS-1:0] gnt_n_q,   gnt_n_d;
    logic                 busrq_n_q, busrq_n_d;

    logic                 pick_valid;
    logic [OWN_W-1:0]     pick_idx;
    logic [N_MASTERS-1:0] pick_onecold;
    logic [OWN_W-1:0]     owner_inc;
    logic                 owner_req;
    logic                 drive_bus;

    rr_pick #(
        .N (N_MASTERS),
        .W (OWN_W)
    ) u_rr_pick (
        .req_i   (~req_n),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            pick_onecold[k] = (pick_idx != OWN_W'(k));
        end
    end

    assign owner_inc = (owner_q == OWN_W'(N_MASTERS - 1)) ? '0 : owner_q + OWN_W'(1);

    // a BUSAK drop while granted strips the bus within the same cycle
    assign drive_bus   = (state_q == ST_GRANT) && !cpu_busak_n;
    assign gnt_n       = drive_bus ? gnt_n_q : '1;
    assign busy        = drive_bus;
    assign owner       = owner_q;
    assign cpu_busrq_n = busrq_n_q;

    always_comb begin
        bus_addr   = BUS_IDLE_ADDR;
        bus_data   = BUS_IDLE_DATA;
        bus_iorq_n = 1'b1;
        bus_mreq_n = 1'b1;
        bus_rd_n   = 1'b1;
        bus_wr_n   = 1'b1;
        owner_req  = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (owner_q == OWN_W'(k)) begin
                owner_req = !req_n[k];
                if (drive_bus) begin
                    bus_addr   = m_addr[16*k +: 16];
                    bus_data   = m_data[8*k +: 8];
                    bus_iorq_n = m_iorq_n[k];
                    bus_mreq_n = m_mreq_n[k];
                    bus_rd_n   = m_rd_n[k];
                    bus_wr_n   = m_wr_n[k];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_n_d   = gnt_n_q;
        busrq_n_d = busrq_n_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    busrq_n_d = 1'b0;
                    state_d   = ST_CPU_REQ;
                end
            end
            ST_CPU_REQ: begin
                if (!pick_valid) begin
                    busrq_n_d = 1'b1;
                    state_d   = ST_CPU_REL;
                end else if (!cpu_busak_n) begin
                    owner_d = pick_idx;
                    gnt_n_d = pick_onecold;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (cpu_busak_n) begin
                    gnt_n_d   = '1;
                    ptr_d     = owner_inc;
                    busrq_n_d = 1'b1;
                    state_d   = ST_CPU_REL;
                end else if (!owner_req) begin
                    gnt_n_d   = '1;
                    ptr_d     = owner_inc;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cpu_busak_n) begin
                    busrq_n_d = 1'b1;
                    state_d   = ST_CPU_REL;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end else if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_n_d = pick_onecold;
                    state_d = ST_GRANT;
                end else begin
                    busrq_n_d = 1'b1;
                    state_d   = ST_CPU_REL;
                end
            end
            ST_CPU_REL: begin
                if (cpu_busak_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_n_d   = '1;
                busrq_n_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_n_q   <= '1;
            busrq_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_n_q   <= gnt_n_d;
            busrq_n_q <= busrq_n_d;
        end
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// tb/tb_z80_bus_arbiter.sv - randomized masters and CPU checked against a transaction-level arbitration model
module tb_z80_bus_arbiter;

    localparam int N   = 3;
    localparam int GAP = 2;
    localparam int OW  = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_n;
    logic [N-1:0]    gnt_n;
    logic            cpu_busrq_n;
    logic            busak_n;
    logic [16*N-1:0] m_addr;
    logic [8*N-1:0]  m_data;
    logic [N-1:0]    m_iorq_n, m_mreq_n, m_rd_n, m_wr_n;
    logic [15:0]     bus_addr;
    logic [7:0]      bus_data;
    logic            bus_iorq_n, bus_mreq_n, bus_rd_n, bus_wr_n;
    logic [OW-1:0]   owner;
    logic            busy;

    logic [15:0] addr_a [N];
    logic [7:0]  data_a [N];
    logic [3:0]  strb_a [N];
    bit          want_a [N];
    int          hold_a [N];
    int          cpu_dly;
    int          rst_left;

    int n_checks = 0;
    int n_errors = 0;

    // model of the arbitration contract: who holds the bus, remaining gap, CPU handshake phase
    int holder, gap_left, ptr, last_owner, grants;
    bit asking, draining;

    z80_bus_arbiter #(
        .N_MASTERS  (N),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_n       (req_n),
        .gnt_n       (gnt_n),
        .cpu_busrq_n (cpu_busrq_n),
        .cpu_busak_n (busak_n),
        .m_addr      (m_addr),
        .m_data      (m_data),
        .m_iorq_n    (m_iorq_n),
        .m_mreq_n    (m_mreq_n),
        .m_rd_n      (m_rd_n),
        .m_wr_n      (m_wr_n),
        .bus_addr    (bus_addr),
        .bus_data    (bus_data),
        .bus_iorq_n  (bus_iorq_n),
        .bus_mreq_n  (bus_mreq_n),
        .bus_rd_n    (bus_rd_n),
        .bus_wr_n    (bus_wr_n),
        .owner       (owner),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_n[k]          = !want_a[k];
            m_addr[16*k +: 16] = addr_a[k];
            m_data[8*k +: 8]   = data_a[k];
            m_iorq_n[k]       = strb_a[k][3];
            m_mreq_n[k]       = strb_a[k][2];
            m_rd_n[k]         = strb_a[k][1];
            m_wr_n[k]         = strb_a[k][0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_winner(input int p);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (want_a[k]) return k;
        end
        return -1;
    endfunction

    task automatic give(input int w);
        holder     = w;
        last_owner = w;
        grants++;
    endtask

    task automatic model_step();
        int w;
        if (!reset_n) begin
            holder = -1; gap_left = 0; ptr = 0; last_owner = 0;
            asking = 1'b0; draining = 1'b0;
        end else if (draining) begin
            if (busak_n) draining = 1'b0;
        end else if (holder >= 0) begin
            if (busak_n) begin
                ptr = (holder + 1) % N; holder = -1;
                asking = 1'b0; draining = 1'b1;
            end else if (!want_a[holder]) begin
                ptr = (holder + 1) % N; holder = -1;
                gap_left = GAP;
            end
        end else if (gap_left > 0) begin
            if (busak_n) begin
                gap_left = 0; asking = 1'b0; draining = 1'b1;
            end else begin
                gap_left--;
                if (gap_left == 0) begin
                    w = rr_winner(ptr);
                    if (w >= 0) give(w);
                    else begin asking = 1'b0; draining = 1'b1; end
                end
            end
        end else if (asking) begin
            w = rr_winner(ptr);
            if (w < 0) begin asking = 1'b0; draining = 1'b1; end
            else if (!busak_n) give(w);
        end else if (rr_winner(ptr) >= 0) begin
            asking = 1'b1;
        end
    endtask

    task automatic drive_stimulus(input int cyc);
        if (cyc < 2) reset_n = 1'b0;
        else if (rst_left > 0) begin reset_n = 1'b0; rst_left--; end
        else if ($urandom_range(0, 399) == 0) begin reset_n = 1'b0; rst_left = $urandom_range(0, 2); end
        else reset_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            addr_a[k] = 16'($urandom);
            data_a[k] = 8'($urandom);
            strb_a[k] = 4'($urandom);
            if (want_a[k]) begin
                if (!gnt_n[k]) begin
                    if (hold_a[k] == 0) want_a[k] = 1'b0;
                    else hold_a[k]--;
                end else if ($urandom_range(0, 59) == 0) begin
                    want_a[k] = 1'b0;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                want_a[k] = 1'b1;
                hold_a[k] = $urandom_range(0, 20);
            end
        end
        if (!cpu_busrq_n) begin
            if (busak_n) begin
                if (cpu_dly == 0) begin busak_n = 1'b0; cpu_dly = $urandom_range(0, 4); end
                else cpu_dly--;
            end else if (busy && $urandom_range(0, 149) == 0) begin
                busak_n = 1'b1; cpu_dly = $urandom_range(0, 4);
            end
        end else if (!busak_n) begin
            if (cpu_dly == 0) begin busak_n = 1'b1; cpu_dly = $urandom_range(0, 4); end
            else cpu_dly--;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_gnt;
        bit live;
        live    = (holder >= 0) && !busak_n;
        exp_gnt = '1;
        if (live) exp_gnt[holder] = 1'b0;
        check("gnt_n", gnt_n, exp_gnt);
        check("cpu_busrq_n", cpu_busrq_n, !asking);
        check("busy", busy, live);
        check("owner", owner, last_owner);
        if (live) begin
            check("bus_addr", bus_addr, addr_a[holder]);
            check("bus_data", bus_data, data_a[holder]);
            check("strobes", {bus_iorq_n, bus_mreq_n, bus_rd_n, bus_wr_n}, strb_a[holder]);
        end else begin
            check("idle_addr", bus_addr, 16'h0000);
            check("idle_data", bus_data, 8'h00);
            check("idle_strobes", {bus_iorq_n, bus_mreq_n, bus_rd_n, bus_wr_n}, 4'hF);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        busak_n  = 1'b1;
        cpu_dly  = 0;
        rst_left = 0;
        for (int k = 0; k < N; k++) begin
            addr_a[k] = '0; data_a[k] = '0; strb_a[k] = 4'hF;
            want_a[k] = 1'b0; hold_a[k] = 0;
        end
        holder = -1; gap_left = 0; ptr = 0; last_owner = 0; grants = 0;
        asking = 1'b0; draining = 1'b0;
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            drive_stimulus(cyc);
            #1;
            check_outputs();
            @(posedge clk);
            model_step();
        end
        check("grant_count_min", grants >= 20, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
- Responder/arbiter side of the DMA bus-request handshake.
- Collects active-low bus requests from up to N_MASTERS DMA-style masters and issues one BUSRQ to the TV80 CPU.
- Waits for CPU BUSAK, then grants the bus to exactly one master using round-robin.
- Muxes the granted master's address, data and strobes onto the shared system bus; all strobes are forced inactive at every ownership change.

Parameters:
- N_MASTERS, 2, number of requesting masters (1..8).
- GAP_CYCLES, 1, idle cycles with all strobes forced high between owners (1..15).
- OWN_W, $clog2(N_MASTERS) with a minimum of 1, width of the owner index.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_n  in  N_MASTERS  per-master bus request (the master's busrq_n).
- gnt_n  out  N_MASTERS  per-master grant (the master's busak_n); one-cold or all-high.
- cpu_busrq_n  out  1  bus request to the CPU.
- cpu_busak_n  in  1  bus acknowledge from the CPU.
- m_addr  in  16*N_MASTERS  master addresses; master k occupies bits [16k+15:16k].
- m_data  in  8*N_MASTERS  master write data; master k occupies bits [8k+7:8k].
- m_iorq_n, m_mreq_n, m_rd_n, m_wr_n  in  N_MASTERS each  master strobes.
- bus_addr  out  16  shared address.
- bus_data  out  8  shared write data.
- bus_iorq_n, bus_mreq_n, bus_rd_n, bus_wr_n  out  1 each  shared strobes.
- owner  out  OWN_W  index of the current grantee.
- busy  out  1  high while any master holds a grant.

Behaviour:
- Reset values (while reset_n is low):
  - cpu_busrq_n=1, gnt_n all 1, bus strobes 1, bus_addr=0, bus_data=0, owner=0, busy=0.
  - Round-robin pointer = 0, FSM = IDLE.
- FSM states: IDLE, CPU_REQ, GRANT, GAP, CPU_REL.
- IDLE:
  - If any req_n bit is low: set cpu_busrq_n=0 and go to CPU_REQ.
- CPU_REQ:
  - Hold cpu_busrq_n=0 and wait for cpu_busak_n=0.
  - Then select the winner as the first low req_n bit scanning upward from pointer, with wrap.
  - Assert that master's gnt_n bit from the next cycle, register owner, go to GRANT.
  - If all requests withdraw before BUSAK: go to CPU_REL.
- GRANT:
  - bus_* outputs combinationally follow master[owner]; busy=1.
  - When req_n[owner] goes high: deassert gnt_n the same clock edge, set pointer = owner+1 (wrap), go to GAP.
  - Requests from other masters never preempt the current owner.
- GAP:
  - Strobes forced high, bus_addr/bus_data forced 0, gnt_n all high, for GAP_CYCLES cycles.
  - At the end: if any req_n is low, select the next winner and return to GRANT, keeping cpu_busrq_n low. Otherwise go to CPU_REL.
- CPU_REL:
  - Set cpu_busrq_n=1 and wait for cpu_busak_n=1, then go to IDLE.
  - New requests arriving here are held until IDLE; there is no shortcut re-request.
- Outside GRANT: all bus_* strobes are high and addr/data are 0.
- Grant latency: cpu_busak_n falling at edge t produces gnt_n low after edge t+1.
- Simultaneous release and new request: release is honoured first and GAP is always inserted.
- CPU drops BUSAK in GRANT or GAP (protocol violation):
  - Force all gnt_n high and strobes inactive immediately, set cpu_busrq_n=1, go to CPU_REL.
  - The pointer still advances past the aborted owner.
- Reset mid-transfer: everything returns to reset values on the next edge; no strobe glitch low.
- Mux inputs from non-owners are ignored entirely.
- At most one gnt_n bit is low at any time.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams ST_IDLE..ST_CPU_REL).
  - GAP counter width = 4.
  - Constants BUS_IDLE_ADDR=16'h0000 and BUS_IDLE_DATA=8'h00.
- One natural sub-module: rr_pick.
  - Combinational round-robin selector: inputs req vector, pointer; outputs valid, index.
  - Reusable by a future interrupt daisy-chain controller.
- Top level holds the FSM, GAP counter and output mux.

Test Plan:
1. Single master, N_MASTERS=2: req_n=2'b10, CPU acks after 3 cycles -> gnt_n=2'b10 one cycle after BUSAK low; bus_addr tracks m_addr[15:0]=16'h8000. After release, cpu_busrq_n=1 within GAP_CYCLES+1 cycles.
2. Round-robin: both masters request continuously, each releasing after 17 cycles -> owners go 0,1,0,1. Each change has exactly GAP_CYCLES cycles with gnt_n=2'b11 and all strobes high, and cpu_busrq_n stays low throughout.
3. No preemption: master 1 requests while master 0 owns -> owner stays 0 until req_n[0]=1. Master 1's m_wr_n=0 never appears on bus_wr_n.
4. Early withdrawal: req_n[0] pulses low for 1 cycle, CPU acks 4 cycles later -> no grant issued; FSM goes CPU_REQ -> CPU_REL, cpu_busrq_n returns high.
5. BUSAK abort: cpu_busak_n forced high mid-GRANT -> next edge gnt_n all high, strobes high, cpu_busrq_n=1. Next grant goes to master 1.
6. Reset mid-write: reset_n low while bus_wr_n=0 -> next edge bus_wr_n=1, gnt_n=2'b11, cpu_busrq_n=1, owner=0.
